// File: rtl/sorting_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_pkg
//  Description : Shared types and constants for the sorting arbiter.
//                arb_state_t : arbiter FSM encoding (IDLE_S / LOCK_S)
//                C_MIN_CH / C_MAX_CH : supported range of requesting sinks
//  Revision    : 1.0 - initial release
// ============================================================================
package sorting_pkg;

    localparam int C_MIN_CH = 2;
    localparam int C_MAX_CH = 16;

    typedef enum logic [0:0] {
        IDLE_S = 1'b0,   // no grant, arbitrating
        LOCK_S = 1'b1    // grant held until the packet's EOP transfers
    } arb_state_t;

endpackage : sorting_pkg
`default_nettype wire

// File: rtl/sorting_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Searches upward from
//                last_grant_i + 1, wrapping modulo NUM_CH, and returns the
//                first asserted request.
//  Ports       : req_i        - request vector, one bit per channel
//                last_grant_i - most recently granted channel
//                found_o      - at least one request asserted
//                winner_o     - selected channel (last_grant_i when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import sorting_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CWIDTH = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CWIDTH-1:0] last_grant_i,
    output logic              found_o,
    output logic [CWIDTH-1:0] winner_o
);

    always_comb begin : p_pick
        logic [CWIDTH-1:0] v_idx;
        found_o  = 1'b0;
        winner_o = last_grant_i;
        v_idx    = '0;
        // Offset 1..NUM_CH: the last granted channel is examined last, so
        // it only wins again when nobody else is asking.
        for (int i = 1; i <= NUM_CH; i++) begin
            v_idx = CWIDTH'((int'(last_grant_i) + i) % NUM_CH);
            if (!found_o && req_i[v_idx]) begin
                found_o  = 1'b1;
                winner_o = v_idx;
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/sorting_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_arbiter
//  Description : Packet-locking round-robin arbiter merging NUM_CH Avalon-ST
//                sinks onto one source feeding the sorter. A channel wins only
//                when it presents valid+SOP; the grant is then held until the
//                EOP beat transfers. One idle cycle separates packets.
//  Ports       : clk_i, srst_n_i (synchronous, active-low)
//                snk_*  - per-channel sink side (flattened NUM_CH x DWIDTH data)
//                src_*  - merged source side, src_channel_o = granted index
//  Config      : SORTING_ARB_DROP_ORPHAN_EN - when defined, beats presented
//                without SOP while idle are accepted and discarded; otherwise
//                they stall until an SOP appears or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sorting_arbiter
    import sorting_pkg::*;
#(
    parameter  int DWIDTH = 8,
    parameter  int NUM_CH = 4,
    localparam int CWIDTH = $clog2(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     srst_n_i,
    input  logic [NUM_CH*DWIDTH-1:0] snk_data_i,
    input  logic [NUM_CH-1:0]        snk_startofpacket_i,
    input  logic [NUM_CH-1:0]        snk_endofpacket_i,
    input  logic [NUM_CH-1:0]        snk_valid_i,
    output logic [NUM_CH-1:0]        snk_ready_o,
    output logic [DWIDTH-1:0]        src_data_o,
    output logic                     src_startofpacket_o,
    output logic                     src_endofpacket_o,
    output logic                     src_valid_o,
    input  logic                     src_ready_i,
    output logic [CWIDTH-1:0]        src_channel_o
);

    // r_grant is the active grant while locked and doubles as last_grant
    // while idle: on EOP it simply keeps the channel that just finished.
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CWIDTH-1:0] r_grant;
    logic [CWIDTH-1:0] w_grant_nxt;

    logic [NUM_CH-1:0] w_req;
    logic              w_found;
    logic [CWIDTH-1:0] w_winner;
    logic [DWIDTH-1:0] w_snk_data [NUM_CH];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_unpack
            assign w_snk_data[g] = snk_data_i[g*DWIDTH +: DWIDTH];
        end
    endgenerate

    // Only a packet start may claim the output.
    assign w_req = snk_valid_i & snk_startofpacket_i;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .CWIDTH (CWIDTH)
    ) u_rr_picker (
        .req_i        (w_req),
        .last_grant_i (r_grant),
        .found_o      (w_found),
        .winner_o     (w_winner)
    );

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state <= IDLE_S;
            r_grant <= CWIDTH'(NUM_CH - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        snk_ready_o         = '0;
        src_data_o          = '0;
        src_startofpacket_o = 1'b0;
        src_endofpacket_o   = 1'b0;
        src_valid_o         = 1'b0;
        src_channel_o       = r_grant;

        case (r_state)
            IDLE_S: begin
                if (w_found) begin
                    w_state_nxt = LOCK_S;
                    w_grant_nxt = w_winner;
                end
`ifdef SORTING_ARB_DROP_ORPHAN_EN
                // Swallow mid-packet beats left over from a truncated stream.
                snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
`endif
            end

            LOCK_S: begin
                src_data_o           = w_snk_data[r_grant];
                src_startofpacket_o  = snk_startofpacket_i[r_grant];
                src_endofpacket_o    = snk_endofpacket_i[r_grant];
                src_valid_o          = snk_valid_i[r_grant];
                snk_ready_o[r_grant] = src_ready_i;
                if (snk_valid_i[r_grant] && src_ready_i && snk_endofpacket_i[r_grant]) begin
                    w_state_nxt = IDLE_S;
                end
            end

            default: begin
                w_state_nxt = IDLE_S;
            end
        endcase
    end

endmodule : sorting_arbiter
`default_nettype wire

// File: tb/tb_sorting_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sorting_arbiter
//  Description : Self-checking bench for sorting_arbiter (NUM_CH=4, DWIDTH=8).
//                Per-channel source queues drive the sinks; expected output
//                beats are queued in predicted grant order and compared when
//                the merged source transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sorting_arbiter;

    localparam int C_DW = 8;
    localparam int C_NC = 4;
    localparam int C_CW = 2;

    logic                   clk_i = 1'b0;
    logic                   srst_n_i;
    logic [C_NC*C_DW-1:0]   snk_data_i;
    logic [C_NC-1:0]        snk_startofpacket_i;
    logic [C_NC-1:0]        snk_endofpacket_i;
    logic [C_NC-1:0]        snk_valid_i;
    logic [C_NC-1:0]        snk_ready_o;
    logic [C_DW-1:0]        src_data_o;
    logic                   src_startofpacket_o;
    logic                   src_endofpacket_o;
    logic                   src_valid_o;
    logic                   src_ready_i;
    logic [C_CW-1:0]        src_channel_o;

    sorting_arbiter #(.DWIDTH(C_DW), .NUM_CH(C_NC)) dut (
        .clk_i               (clk_i),
        .srst_n_i            (srst_n_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i),
        .src_channel_o       (src_channel_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [C_DW-1:0] data;
        logic            sop;
        logic            eop;
    } beat_t;

    typedef struct packed {
        logic [C_CW-1:0] ch;
        logic [C_DW-1:0] data;
        logic            sop;
        logic            eop;
    } exp_t;

    beat_t      ch_q [C_NC][$];
    exp_t       exp_q[$];
    logic [C_NC-1:0] xfer;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         chk_gap   = 1'b0;
    bit         gap_armed = 1'b0;
    int         gap_cnt   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_beat(input int ch, input logic [7:0] data, input bit sop, input bit eop,
                             input bit to_exp);
        beat_t b;
        exp_t  e;
        b = '{data: data, sop: sop, eop: eop};
        ch_q[ch].push_back(b);
        if (to_exp) begin
            e = '{ch: C_CW'(ch), data: data, sop: sop, eop: eop};
            exp_q.push_back(e);
        end
    endtask

    task automatic send_pkt(input int ch, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            push_beat(ch, base + 8'(i), (i == 0), (i == n - 1), 1'b1);
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int ch = 0; ch < C_NC; ch++) begin
            if (ch_q[ch].size() > 0) begin
                b = ch_q[ch][0];
                snk_valid_i[ch]             = 1'b1;
                snk_data_i[ch*C_DW +: C_DW] = b.data;
                snk_startofpacket_i[ch]     = b.sop;
                snk_endofpacket_i[ch]       = b.eop;
            end else begin
                snk_valid_i[ch]             = 1'b0;
                snk_data_i[ch*C_DW +: C_DW] = '0;
                snk_startofpacket_i[ch]     = 1'b0;
                snk_endofpacket_i[ch]       = 1'b0;
            end
        end
    endtask

    task automatic clear_sources();
        for (int ch = 0; ch < C_NC; ch++) ch_q[ch].delete();
    endtask

    // Observe at the falling edge; everything is stable until the next rise.
    task automatic sample();
        exp_t e;
        @(negedge clk_i);
        xfer = snk_valid_i & snk_ready_o;
        if (src_valid_o && src_ready_i) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("beat_data", 32'(src_data_o), 32'(e.data));
                check_val("beat_sop",  32'(src_startofpacket_o), 32'(e.sop));
                check_val("beat_eop",  32'(src_endofpacket_o), 32'(e.eop));
                check_val("beat_chan", 32'(src_channel_o), 32'(e.ch));
            end
            check_val("ready_mask", 32'(snk_ready_o), 32'(4'b0001 << src_channel_o));
            if (chk_gap && gap_armed && src_startofpacket_o) begin
                check_val("idle_gap", 32'(gap_cnt), 32'd1);
                gap_armed = 1'b0;
            end
            if (src_endofpacket_o) begin
                gap_armed = 1'b1;
                gap_cnt   = 0;
            end
        end else if (gap_armed && !src_valid_o) begin
            gap_cnt++;
        end
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
        for (int ch = 0; ch < C_NC; ch++)
            if (xfer[ch] && ch_q[ch].size() > 0) void'(ch_q[ch].pop_front());
        drive_inputs();
    endtask

    function automatic bit all_done();
        bit d;
        d = (exp_q.size() == 0);
        for (int ch = 0; ch < C_NC; ch++) if (ch_q[ch].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles && !all_done(); k++) begin
            sample();
            advance();
        end
        check_val("drain_done", 32'(all_done()), 32'd1);
        exp_q.delete();
        clear_sources();
        drive_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst_n_i    = 1'b0;
        src_ready_i = 1'b1;
        xfer        = '0;
        drive_inputs();
        repeat (3) @(posedge clk_i);
        #1;

        // Reset values
        sample();
        check_val("rst_valid", 32'(src_valid_o), 32'd0);
        check_val("rst_ready", 32'(snk_ready_o), 32'd0);
        check_val("rst_chan",  32'(src_channel_o), 32'd3);
        advance();

        // Basic 3-beat packet on ch0, one-cycle bubble before the SOP
        srst_n_i = 1'b1;
        push_beat(0, 8'h05, 1'b1, 1'b0, 1'b1);
        push_beat(0, 8'h01, 1'b0, 1'b0, 1'b1);
        push_beat(0, 8'h03, 1'b0, 1'b1, 1'b1);
        drive_inputs();
        sample();
        check_val("first_bubble", 32'(src_valid_o), 32'd0);
        advance();
        sample();
        check_val("first_out_valid", 32'(src_valid_o), 32'd1);
        advance();
        drain(20);
        check_val("idle_last_grant0", 32'(src_channel_o), 32'd0);

        // Single-beat packet on ch1 sets last_grant=1
        push_beat(1, 8'h11, 1'b1, 1'b1, 1'b1);
        drive_inputs();
        drain(10);
        check_val("idle_last_grant1", 32'(src_channel_o), 32'd1);

        // ch1 and ch3 together: ch3 first, then ch1, not interleaved
        send_pkt(3, 2, 8'h30);
        send_pkt(1, 2, 8'h10);
        drive_inputs();
        drain(30);
        check_val("idle_last_grant_after_pair", 32'(src_channel_o), 32'd1);

        // Fresh reset, then all four channels busy: order 0,1,2,3,0
        srst_n_i = 1'b0;
        sample();
        advance();
        srst_n_i  = 1'b1;
        gap_armed = 1'b0;
        chk_gap   = 1'b1;
        send_pkt(0, 2, 8'h40);
        send_pkt(1, 2, 8'h50);
        send_pkt(2, 2, 8'h60);
        send_pkt(3, 2, 8'h70);
        send_pkt(0, 2, 8'h80);
        drive_inputs();
        drain(60);
        chk_gap   = 1'b0;
        gap_armed = 1'b0;

        // Back-pressure for 5 cycles mid-packet on ch2 with ch0 waiting
        send_pkt(2, 4, 8'hA0);
        drive_inputs();
        sample();
        advance();
        sample();
        advance();
        src_ready_i = 1'b0;
        send_pkt(0, 2, 8'hC0);
        drive_inputs();
        for (int k = 0; k < 5; k++) begin
            sample();
            check_val("stall_valid", 32'(src_valid_o), 32'd1);
            check_val("stall_data",  32'(src_data_o), 32'hA1);
            check_val("stall_sop",   32'(src_startofpacket_o), 32'd0);
            check_val("stall_ready", 32'(snk_ready_o), 32'd0);
            check_val("stall_chan",  32'(src_channel_o), 32'd2);
            advance();
        end
        src_ready_i = 1'b1;
        drive_inputs();
        drain(30);

        // Orphan beat (valid without SOP) on ch1 while idle
        push_beat(1, 8'hEE, 1'b0, 1'b0, 1'b0);
        drive_inputs();
        sample();
`ifdef SORTING_ARB_DROP_ORPHAN_EN
        check_val("orphan_ready", 32'(snk_ready_o[1]), 32'd1);
`else
        check_val("orphan_ready", 32'(snk_ready_o[1]), 32'd0);
`endif
        check_val("orphan_valid", 32'(src_valid_o), 32'd0);
        advance();
`ifdef SORTING_ARB_DROP_ORPHAN_EN
        check_val("orphan_consumed", 32'(ch_q[1].size()), 32'd0);
`endif
        clear_sources();
        drive_inputs();
        sample();
        check_val("orphan_no_lock", 32'(src_valid_o), 32'd0);
        advance();

        // Reset during the second beat of a 4-beat packet on ch2
        send_pkt(2, 4, 8'hD0);
        drive_inputs();
        sample();
        advance();
        sample();
        advance();
        srst_n_i = 1'b0;
        sample();
        advance();
        srst_n_i = 1'b1;
        check_val("trunc_pending", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        clear_sources();
        send_pkt(0, 2, 8'hF0);
        send_pkt(3, 2, 8'hE0);
        drive_inputs();
        sample();
        check_val("post_rst_valid", 32'(src_valid_o), 32'd0);
        check_val("post_rst_chan",  32'(src_channel_o), 32'd3);
        check_val("post_rst_ready", 32'(snk_ready_o), 32'd0);
        advance();
        drain(30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sorting_arbiter
`default_nettype wire
